// File: rtl/milano_fetch_stage.sv
// Instruction fetch stage: issues word fetches under a credit limit, buffers
// {pc, instr} pairs in an in-order FIFO and hands them to decode; redirects flush.
module milano_fetch_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_pc_mem  [FIFO_DEPTH];
  logic [31:0]   r_ins_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_grant;
  logic [CW+1:0] w_used;
  logic [31:0]   w_target;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign w_valid  = (r_occ != '0);
  assign w_pop    = w_valid && instr_ready_i;
  assign w_target = branch_addr_i & 32'hFFFF_FFFC;

  // Every buffered, in-flight or to-be-dropped word holds a credit; a pop this
  // cycle frees one early, hence the intended ready->req combinational path.
  assign w_used = (CW + 2)'(r_occ) + (CW + 2)'(r_outst) + (CW + 2)'(r_discard)
                - (CW + 2)'(w_pop);

  assign instr_req_o  = !rst_i && !branch_i && (w_used < DEPTH_W);
  assign instr_addr_o = r_fetch_pc;
  assign w_grant      = instr_req_o && instr_gnt_i;
  assign w_drop       = instr_rvalid_i && (r_discard != '0);
  assign w_push       = instr_rvalid_i && (r_discard == '0) && !branch_i;

  assign instr_valid_o = w_valid;
  assign instr_rdata_o = w_valid ? r_ins_mem[r_rd_ptr] : NOP;
  assign instr_pc_o    = w_valid ? r_pc_mem[r_rd_ptr]  : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
      r_fetch_pc <= BOOT_ADDR;
      r_resp_pc  <= BOOT_ADDR;
    end else if (branch_i) begin
      // A response arriving in the redirect cycle is the oldest stale word, so
      // it consumes one of the credits being turned into discards.
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
      r_outst    <= '0;
      r_discard  <= r_discard + r_outst - CW'(instr_rvalid_i);
      r_fetch_pc <= w_target;
      r_resp_pc  <= w_target;
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      if (w_drop) begin
        r_discard <= r_discard - CW'(1);
      end
      r_occ   <= r_occ + CW'(w_push) - CW'(w_pop);
      r_outst <= r_outst + CW'(w_grant) - CW'(w_push);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_resp_pc;
      r_ins_mem[r_wr_ptr] <= instr_rdata_i;
    end
  end

endmodule

// File: tb/tb_milano_fetch_stage.sv
// Bench for milano_fetch_stage: directed vector table, redirect/wrap/reset
// sequences and a randomized run against a queue-based reference model.
module tb_milano_fetch_stage;

  localparam logic [31:0] BOOT  = 32'h0000_0100;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i    = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i  = '0;
  logic        branch_i       = 1'b0;
  logic [31:0] branch_addr_i  = '0;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i  = 1'b0;

  milano_fetch_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .instr_valid_o  (instr_valid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_pc_o     (instr_pc_o),
    .instr_ready_i  (instr_ready_i)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int mem_lat = 1;
  int m_lastdue = 0;

  // Memory: outstanding granted addresses with the cycle their data returns
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       memq[$];
  logic [31:0] glog[$];

  // Reference model: in-flight requests tagged stale on redirect, output queue
  typedef struct { logic [31:0] pc; bit stale; } inf_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  inf_t        m_inf[$];
  ent_t        m_fifo[$];
  logic [31:0] m_fpc = BOOT;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_rdata;

  typedef struct {
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[18];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + {a[15:0], a[31:16]};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  task automatic cycle_run(input bit rdy, input bit gnt, input bit br, input logic [31:0] baddr);
    bit          rv, pop, e_req, e_valid;
    logic [31:0] rd, e_pc, e_rd;
    int          due;
    inf_t        e;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    rd = rv ? mem_data(memq[0].addr) : $urandom;
    instr_ready_i  = rdy;
    instr_gnt_i    = gnt;
    branch_i       = br;
    branch_addr_i  = baddr;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    #1;
    e_valid = m_fifo.size() > 0;
    pop     = e_valid && rdy;
    e_req   = !br && ((m_fifo.size() + m_inf.size() - int'(pop)) < DEPTH);
    e_pc    = e_valid ? m_fifo[0].pc  : 32'h0;
    e_rd    = e_valid ? m_fifo[0].ins : NOP;
    s_req = instr_req_o;  s_addr = instr_addr_o;  s_valid = instr_valid_o;
    s_pc  = instr_pc_o;   s_rdata = instr_rdata_o;
    chk("req",   32'(s_req),   32'(e_req));
    chk("addr",  s_addr,       m_fpc);
    chk("valid", 32'(s_valid), 32'(e_valid));
    chk("pc",    s_pc,         e_pc);
    chk("rdata", s_rdata,      e_rd);
    @(posedge clk);
    if (rv) void'(memq.pop_front());
    if (s_req && gnt) begin
      due = cyc + mem_lat;
      if (due <= m_lastdue) due = m_lastdue + 1;
      m_lastdue = due;
      memq.push_back('{s_addr, due});
      glog.push_back(s_addr);
    end
    if (br) begin
      m_fifo.delete();
      if (rv && m_inf.size() > 0) void'(m_inf.pop_front());
      foreach (m_inf[i]) m_inf[i].stale = 1'b1;
      m_fpc = {baddr[31:2], 2'b00};
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (rv && m_inf.size() > 0) begin
        e = m_inf.pop_front();
        if (!e.stale) m_fifo.push_back('{e.pc, rd});
      end
      if (e_req && gnt) begin
        m_inf.push_back('{m_fpc, 1'b0});
        m_fpc = m_fpc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Called just after a falling edge; reset lands mid-cycle, away from any edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_req",   32'(instr_req_o),   32'h0);
    chk("rst_addr",  instr_addr_o,       BOOT);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_rdata", instr_rdata_o,      NOP);
    chk("rst_pc",    instr_pc_o,         32'h0);
    memq.delete();  m_inf.delete();  m_fifo.delete();
    m_fpc = BOOT;
    instr_rvalid_i = 1'b0;  instr_gnt_i = 1'b0;  branch_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
      found = s_valid;
    end
    chk(name, 32'(found), 32'h1);
  endtask

  task automatic fill_outstanding(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (memq.size() == 2) ok = 1'b1;
      else cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk(name, 32'(ok), 32'h1);
  endtask

  initial begin
    logic [31:0] vpcs[$];
    bit          ok;

    tbl[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h000};
    tbl[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h000};
    tbl[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    tbl[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    tbl[4]  = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    for (int i = 5; i < 15; i++) tbl[i] = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C};
    tbl[15] = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
    tbl[16] = '{1'b1, 1'b1, 32'h118, 1'b1, 32'h110};
    tbl[17] = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h114};

    @(negedge clk);
    do_reset();

    // Zero-wait streaming from BOOT, then 10 cycles of backpressure
    mem_lat = 1;
    for (int i = 0; i < 18; i++) begin
      cycle_run(tbl[i].rdy, 1'b1, 1'b0, 32'h0);
      chk("tbl_req",   32'(s_req),   32'(tbl[i].req));
      chk("tbl_addr",  s_addr,       tbl[i].addr);
      chk("tbl_valid", 32'(s_valid), 32'(tbl[i].valid));
      chk("tbl_pc",    s_pc,         tbl[i].pc);
      chk("tbl_rdata", s_rdata,      tbl[i].valid ? mem_data(tbl[i].pc) : NOP);
    end

    // Redirect with two slow responses still in flight
    mem_lat = 3;
    fill_outstanding("br_setup");
    cycle_run(1'b1, 1'b1, 1'b1, 32'h0000_2002);
    chk("br_req", 32'(s_req), 32'h0);
    cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
    chk("br_valid_next", 32'(s_valid), 32'h0);
    wait_valid("br_timeout", 30);
    chk("br_first_pc",   s_pc,    32'h0000_2000);
    chk("br_first_data", s_rdata, mem_data(32'h0000_2000));

    // Redirect coinciding with a response and a pop, target near top of memory
    mem_lat = 1;
    repeat (6) cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && m_fifo.size() > 0) ok = 1'b1;
      else cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("wrap_setup", 32'(ok), 32'h1);
    cycle_run(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB);
    chk("wrap_br_req",   32'(s_req),   32'h0);
    chk("wrap_br_valid", 32'(s_valid), 32'h1);
    glog.delete();
    for (int i = 0; i < 10; i++) begin
      cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
      if (s_valid) vpcs.push_back(s_pc);
    end
    chk("wrap_ngrants", 32'(glog.size() >= 3), 32'h1);
    chk("wrap_nvalid",  32'(vpcs.size() >= 3), 32'h1);
    if (glog.size() >= 3 && vpcs.size() >= 3) begin
      chk("wrap_gaddr0", glog[0], 32'hFFFF_FFF8);
      chk("wrap_gaddr1", glog[1], 32'hFFFF_FFFC);
      chk("wrap_gaddr2", glog[2], 32'h0000_0000);
      chk("wrap_pc0",    vpcs[0], 32'hFFFF_FFF8);
      chk("wrap_pc1",    vpcs[1], 32'hFFFF_FFFC);
      chk("wrap_pc2",    vpcs[2], 32'h0000_0000);
    end

    // Asynchronous reset with two requests outstanding
    mem_lat = 3;
    fill_outstanding("rst_setup");
    do_reset();
    mem_lat = 1;
    cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_first_req",  32'(s_req), 32'h1);
    chk("rst_first_addr", s_addr,     BOOT);
    wait_valid("rst_timeout", 10);
    chk("rst_first_pc",   s_pc,    BOOT);
    chk("rst_first_data", s_rdata, mem_data(BOOT));

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(1, 4);
      cycle_run($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                $urandom_range(0, 29) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
